uart_tx_buffered: RTL

Parametrised successor to the single-byte UART transmit path between the core and the serial pin. It adds an N-entry transmit FIFO so the core can post several characters without polling per byte. Baud divisor, data width, stop-bit count and FIFO depth are parametrised. It sits between the core's store-to-UART path and the txd pin, and replaces the direct sdata/tx_ready handshake with a push/full handshake.

---
 rtl/uart_tx_buffered.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: 2**DEPTH_LOG-entry FIFO feeding an 8N1-style framer.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx_buffered #(
  parameter int CLK_PER_BIT = 868,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int DEPTH_LOG   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 full,
  output logic [DEPTH_LOG:0]   count,
  output logic                 busy,
  output logic                 overflow,
  output logic                 txd
);

  localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_PER_BIT - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [DEPTH_LOG:0] DEPTH = {1'b1, {DEPTH_LOG{1'b0}}};

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  logic [DATA_BITS-1:0] r_mem [0:(1<<DEPTH_LOG)-1];
  logic [DEPTH_LOG-1:0] r_wptr;
  logic [DEPTH_LOG-1:0] r_rptr;
  logic [DEPTH_LOG:0]   r_count;
  logic [DEPTH_LOG:0]   w_count_nxt;
  logic                 r_full;
  logic                 r_ovf;
  logic                 r_busy;
  logic                 r_txd;
  logic                 w_txd_nxt;
  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [3:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_bit_end;
  logic                 w_last_data;
  logic                 w_last_stop;
  logic                 w_after_data;
`ifdef UART_TX_PARITY_EN
  logic                 r_par;
`endif

  assign w_push      = wr_en & ~r_full;
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
  assign w_bit_end   = (r_cnt == CNT_MAX);
  assign w_last_data = (r_bit == DATA_LAST);
  assign w_last_stop = (r_bit == STOP_LAST);

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + (DEPTH_LOG+1)'(1);
      2'b01:   w_count_nxt = r_count - (DEPTH_LOG+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push && !rst) r_mem[r_wptr] <= wr_data;
  end

  // A push while full is dropped even if a pop frees a slot this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == DEPTH);
      if (wr_en && r_full) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

`ifdef UART_TX_PARITY_EN
  assign w_after_data = r_par;
`else
  assign w_after_data = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_pop) w_state_nxt = S_START;
      S_START: if (w_bit_end) w_state_nxt = S_DATA;
`ifdef UART_TX_PARITY_EN
      S_DATA:   if (w_bit_end && w_last_data) w_state_nxt = S_PARITY;
      S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
`else
      S_DATA:  if (w_bit_end && w_last_data) w_state_nxt = S_STOP;
`endif
      S_STOP:  if (w_bit_end && w_last_stop) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_txd_nxt = r_txd;
    unique case (r_state)
      S_IDLE:  w_txd_nxt = ~w_pop;
      S_START: if (w_bit_end) w_txd_nxt = r_shift[0];
      S_DATA:
        if (w_bit_end)
          w_txd_nxt = w_last_data ? w_after_data : r_shift[1];
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (w_bit_end) w_txd_nxt = 1'b1;
`endif
      S_STOP:  w_txd_nxt = 1'b1;
      default: w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_txd  <= w_txd_nxt;
      r_busy <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
      if (r_state == S_IDLE || w_bit_end) r_cnt <= '0;
      else                                r_cnt <= r_cnt + 1'b1;
      if (w_bit_end && r_state != S_IDLE)
        r_bit <= (w_state_nxt != r_state) ? 4'd0 : r_bit + 4'd1;
      if (w_pop)
        r_shift <= r_mem[r_rptr];
      else if (r_state == S_DATA && w_bit_end)
        r_shift <= r_shift >> 1;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)        r_par <= 1'b0;
    else if (w_pop) r_par <= ^r_mem[r_rptr];
  end
`endif

  assign full     = r_full;
  assign count    = r_count;
  assign busy     = r_busy;
  assign overflow = r_ovf;
  assign txd      = r_txd;

endmodule
